// File: rtl/senha_pkg.sv
// Shared types for the keypad code-capture block: digit width, digit type and FSM states.
package senha_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {ENTRY, CHECK, DISARMED, LOCKED} senha_state_t;

  typedef logic [DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/registrador_digitos.sv
// Buffer of N_DIGITS entered digits: one synchronous write port, one combinational read port.
module registrador_digitos
  import senha_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int IW       = $clog2(N_DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  digit_t        wr_data,
  input  logic [IW-1:0] rd_idx,
  output digit_t        rd_data
);

  digit_t mem [N_DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DIGITS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/captura_senha.sv
// Keypad code capture: buffers N_DIGITS digits, streams them to the external comparator on enter,
// and tracks disarm / failed tries / lockout. Optional idle timeout: CAPTURA_SENHA_TIMEOUT_EN.
module captura_senha
  import senha_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           key_valid,
  input  digit_t                         key_digit,
  input  logic                           key_clear,
  input  logic                           key_enter,
  output digit_t                         cmp_q1,
  output logic [$clog2(N_DIGITS)-1:0]    cmp_idx,
  output logic                           cmp_enable,
  input  logic                           cmp_s,
  output logic [$clog2(N_DIGITS+1)-1:0]  digit_count,
  output logic                           disarmed,
  output logic                           fail,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
  output logic                           locked
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);

  senha_state_t  state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          acc, acc_nxt;
  logic [TW-1:0] tries, tries_nxt;
  logic          fail_r, fail_nxt;
  logic          wr_en;
  logic          timeout;
  digit_t        rd_data;
  logic          any_key;

  assign any_key = key_valid | key_clear | key_enter;

  registrador_digitos #(.N_DIGITS(N_DIGITS), .IW(IW)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (cnt[IW-1:0]),
    .wr_data (key_digit),
    .rd_idx  (idx),
    .rd_data (rd_data)
  );

`ifdef CAPTURA_SENHA_TIMEOUT_EN
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
  logic [OW-1:0] idle;

  assign timeout = (state == ENTRY) && !any_key && (cnt != '0) && (idle == OW'(TIMEOUT_CYCLES - 1));

  // Idle cycles are only counted while a partial entry is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle <= '0;
    end else if (state != ENTRY || any_key || cnt == '0 || timeout) begin
      idle <= '0;
    end else begin
      idle <= idle + OW'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ENTRY;
      cnt    <= '0;
      idx    <= '0;
      acc    <= 1'b0;
      tries  <= TW'(MAX_TRIES);
      fail_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      acc    <= acc_nxt;
      tries  <= tries_nxt;
      fail_r <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    acc_nxt   = acc;
    tries_nxt = tries;
    fail_nxt  = 1'b0;
    wr_en     = 1'b0;
    case (state)
      ENTRY: begin
        if (key_clear) begin
          cnt_nxt = '0;
        end else if (key_enter) begin
          if (cnt == CW'(N_DIGITS)) begin
            state_nxt = CHECK;
            idx_nxt   = '0;
            acc_nxt   = 1'b1;
          end
        end else if (key_valid) begin
          if (cnt < CW'(N_DIGITS)) begin
            wr_en   = 1'b1;
            cnt_nxt = cnt + CW'(1);
          end
        end else if (timeout) begin
          cnt_nxt = '0;
        end
      end
      CHECK: begin
        acc_nxt = acc & cmp_s;
        idx_nxt = idx + IW'(1);
        if (idx == IW'(N_DIGITS - 1)) begin
          idx_nxt = '0;
          if (acc & cmp_s) begin
            state_nxt = DISARMED;
          end else begin
            fail_nxt  = 1'b1;
            cnt_nxt   = '0;
            if (tries != '0) tries_nxt = tries - TW'(1);
            state_nxt = (tries <= TW'(1)) ? LOCKED : ENTRY;
          end
        end
      end
      default: ;
    endcase
  end

  assign cmp_enable  = (state == CHECK);
  assign cmp_idx     = cmp_enable ? idx : '0;
  assign cmp_q1      = cmp_enable ? rd_data : '0;
  assign digit_count = cnt;
  assign disarmed    = (state == DISARMED);
  assign locked      = (state == LOCKED);
  assign fail        = fail_r;
  assign tries_left  = tries;

endmodule

// File: tb/tb_captura_senha.sv
// Directed bench for captura_senha with a behavioural digit comparator holding secret 1,9,8,4.
module tb_captura_senha;
  import senha_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  digit_t     key_digit = '0;
  logic       key_clear = 1'b0;
  logic       key_enter = 1'b0;
  digit_t     cmp_q1;
  logic [1:0] cmp_idx;
  logic       cmp_enable;
  logic       cmp_s;
  logic [2:0] digit_count;
  logic       disarmed;
  logic       fail;
  logic [1:0] tries_left;
  logic       locked;

  int n_cmp = 0;
  int n_bad = 0;

  digit_t secret [4];
  assign secret[0] = 4'd1;
  assign secret[1] = 4'd9;
  assign secret[2] = 4'd8;
  assign secret[3] = 4'd4;

  // External 4-bit comparator: q2 is the stored secret digit selected by cmp_idx.
  assign cmp_s = cmp_enable && (cmp_q1 == secret[cmp_idx]);

  always #5 clk = ~clk;

  captura_senha #(.N_DIGITS(4), .MAX_TRIES(3), .TIMEOUT_CYCLES(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .key_clear   (key_clear),
    .key_enter   (key_enter),
    .cmp_q1      (cmp_q1),
    .cmp_idx     (cmp_idx),
    .cmp_enable  (cmp_enable),
    .cmp_s       (cmp_s),
    .digit_count (digit_count),
    .disarmed    (disarmed),
    .fail        (fail),
    .tries_left  (tries_left),
    .locked      (locked)
  );

  task automatic key(input digit_t d);
    key_valid = 1'b1;
    key_digit = d;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic enter();
    key_enter = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic attempt(input digit_t d0, input digit_t d1, input digit_t d2, input digit_t d3);
    key(d0); key(d1); key(d2); key(d3);
    enter();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cmp_q1, cmp_idx, cmp_enable, digit_count, disarmed, fail, locked, tries_left} !==
        {4'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd3}) begin
      n_bad++;
      $display("FAIL reset_values: got q1=%0d idx=%0d en=%b cnt=%0d dis=%b fail=%b lock=%b tries=%0d, want 0 0 0 0 0 0 0 3",
               cmp_q1, cmp_idx, cmp_enable, digit_count, disarmed, fail, locked, tries_left);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_correct_code();
    int fails_seen;
    do_reset();
    fails_seen = 0;
    key(4'd1); key(4'd9); key(4'd8); key(4'd4);
    n_cmp++;
    if (digit_count !== 3'd4) begin
      n_bad++; $display("FAIL correct_count: got %0d want 4", digit_count);
    end
    enter();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({cmp_enable, cmp_idx, cmp_q1} !== {1'b1, 2'(i), secret[i]}) begin
        n_bad++;
        $display("FAIL correct_check_cycle%0d: got en=%b idx=%0d q1=%0d want 1 %0d %0d",
                 i, cmp_enable, cmp_idx, cmp_q1, i, secret[i]);
      end
      if (fail) fails_seen++;
      @(negedge clk);
    end
    n_cmp++;
    if ({disarmed, cmp_enable, fail, fails_seen} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      n_bad++;
      $display("FAIL correct_disarm: got dis=%b en=%b fail=%b fails_seen=%0d want 1 0 0 0",
               disarmed, cmp_enable, fail, fails_seen);
    end
    key(4'd3); enter(); @(negedge clk);
    n_cmp++;
    if ({disarmed, cmp_enable} !== 2'b10) begin
      n_bad++; $display("FAIL disarmed_terminal: got dis=%b en=%b want 1 0", disarmed, cmp_enable);
    end
  endtask

  task automatic test_wrong_digit();
    do_reset();
    attempt(4'd1, 4'd9, 4'd7, 4'd4);
    n_cmp++;
    if ({fail, tries_left, digit_count, cmp_enable, disarmed, locked} !== {1'b1, 2'd2, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL wrong_digit: got fail=%b tries=%0d cnt=%0d en=%b dis=%b lock=%b want 1 2 0 0 0 0",
               fail, tries_left, digit_count, cmp_enable, disarmed, locked);
    end
    @(negedge clk);
    n_cmp++;
    if (fail !== 1'b0) begin
      n_bad++; $display("FAIL fail_pulse_width: got %b want 0", fail);
    end
    key(4'd5);
    n_cmp++;
    if (digit_count !== 3'd1) begin
      n_bad++; $display("FAIL back_in_entry: got cnt=%0d want 1", digit_count);
    end
  endtask

  task automatic test_lockout();
    int en_seen;
    do_reset();
    attempt(4'd2, 4'd9, 4'd8, 4'd4);
    attempt(4'd1, 4'd9, 4'd8, 4'd5);
    n_cmp++;
    if ({tries_left, locked} !== {2'd1, 1'b0}) begin
      n_bad++; $display("FAIL lockout_second: got tries=%0d lock=%b want 1 0", tries_left, locked);
    end
    attempt(4'd0, 4'd0, 4'd0, 4'd0);
    n_cmp++;
    if ({locked, tries_left, fail} !== {1'b1, 2'd0, 1'b1}) begin
      n_bad++; $display("FAIL lockout_third: got lock=%b tries=%0d fail=%b want 1 0 1", locked, tries_left, fail);
    end
    en_seen = 0;
    key(4'd1); key(4'd9); key(4'd8); key(4'd4);
    key_enter = 1'b1;
    @(negedge clk);
    key_enter = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (cmp_enable) en_seen++;
      @(negedge clk);
    end
    n_cmp++;
    if ({locked, disarmed, tries_left, fail, digit_count} !== {1'b1, 1'b0, 2'd0, 1'b0, 3'd0} || en_seen != 0) begin
      n_bad++;
      $display("FAIL lockout_ignores_entry: got lock=%b dis=%b tries=%0d fail=%b cnt=%0d en_cycles=%0d want 1 0 0 0 0 0",
               locked, disarmed, tries_left, fail, digit_count, en_seen);
    end
  endtask

  task automatic test_boundaries();
    do_reset();
    key(4'd1); key(4'd9); key(4'd8); key(4'd4); key(4'd5);
    n_cmp++;
    if (digit_count !== 3'd4) begin
      n_bad++; $display("FAIL fifth_digit: got cnt=%0d want 4", digit_count);
    end
    enter();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (disarmed !== 1'b1) begin
      n_bad++; $display("FAIL fifth_digit_no_overwrite: got dis=%b want 1", disarmed);
    end

    do_reset();
    key(4'd1); key(4'd9);
    enter();
    n_cmp++;
    if ({cmp_enable, tries_left, digit_count} !== {1'b0, 2'd3, 3'd2}) begin
      n_bad++;
      $display("FAIL short_enter: got en=%b tries=%0d cnt=%0d want 0 3 2", cmp_enable, tries_left, digit_count);
    end

    key_clear = 1'b1;
    key_valid = 1'b1;
    key_digit = 4'd7;
    @(negedge clk);
    key_clear = 1'b0;
    key_valid = 1'b0;
    n_cmp++;
    if (digit_count !== 3'd0) begin
      n_bad++; $display("FAIL clear_beats_valid: got cnt=%0d want 0", digit_count);
    end

    key(4'd1); key(4'd9); key(4'd8); key(4'd4);
    key_clear = 1'b1;
    key_enter = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
    key_enter = 1'b0;
    n_cmp++;
    if ({cmp_enable, digit_count} !== {1'b0, 3'd0}) begin
      n_bad++; $display("FAIL clear_beats_enter: got en=%b cnt=%0d want 0 0", cmp_enable, digit_count);
    end
  endtask

  task automatic test_reset_mid_check();
    do_reset();
    key(4'd1); key(4'd9); key(4'd7); key(4'd4);
    enter();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cmp_enable, cmp_idx} !== {1'b1, 2'd2}) begin
      n_bad++; $display("FAIL mid_check_position: got en=%b idx=%0d want 1 2", cmp_enable, cmp_idx);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmp_q1, cmp_idx, cmp_enable, digit_count, disarmed, fail, locked, tries_left} !==
        {4'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd3}) begin
      n_bad++;
      $display("FAIL reset_mid_check: got q1=%0d idx=%0d en=%b cnt=%0d dis=%b fail=%b lock=%b tries=%0d, want 0 0 0 0 0 0 0 3",
               cmp_q1, cmp_idx, cmp_enable, digit_count, disarmed, fail, locked, tries_left);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({fail, tries_left, cmp_enable} !== {1'b0, 2'd3, 1'b0}) begin
      n_bad++; $display("FAIL reset_no_fail: got fail=%b tries=%0d en=%b want 0 3 0", fail, tries_left, cmp_enable);
    end
  endtask

`ifdef CAPTURA_SENHA_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    key(4'd1); key(4'd9);
    repeat (9) @(negedge clk);
    n_cmp++;
    if (digit_count !== 3'd2) begin
      n_bad++; $display("FAIL timeout_early: got cnt=%0d want 2", digit_count);
    end
    @(negedge clk);
    n_cmp++;
    if ({digit_count, tries_left} !== {3'd0, 2'd3}) begin
      n_bad++; $display("FAIL timeout_expire: got cnt=%0d tries=%0d want 0 3", digit_count, tries_left);
    end
    key(4'd1); key(4'd9);
    repeat (8) @(negedge clk);
    key(4'd8);
    repeat (9) @(negedge clk);
    n_cmp++;
    if (digit_count !== 3'd3) begin
      n_bad++; $display("FAIL timeout_restart: got cnt=%0d want 3", digit_count);
    end
    @(negedge clk);
    n_cmp++;
    if (digit_count !== 3'd0) begin
      n_bad++; $display("FAIL timeout_after_restart: got cnt=%0d want 0", digit_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_correct_code();
    test_wrong_digit();
    test_lockout();
    test_boundaries();
    test_reset_mid_check();
`ifdef CAPTURA_SENHA_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
